// File: rtl/qcl_subgroup_board_concentrator_pkg.sv
// Shared types and constants for the subgroup board concentrator.
package qcl_subgroup_board_concentrator_pkg;

    localparam int max_proc_nodes_gp = 8;

    typedef enum logic {
        IDLE,
        LOCK
    } qcl_conc_state_e;

endpackage

// File: rtl/qcl_subgroup_board_concentrator_if.sv
// Board-side, upstream and return-path signals of the concentrator.
interface qcl_subgroup_board_concentrator_if
    import qcl_subgroup_board_concentrator_pkg::*;
#(
    parameter int num_boards_p   = 4,
    parameter int data_width_p   = 32,
    parameter int brd_id_width_p = $clog2(max_proc_nodes_gp)
);

    logic [num_boards_p-1:0]                   brd_v_i;
    logic [num_boards_p-1:0][data_width_p-1:0] brd_data_i;
    logic [num_boards_p-1:0]                   brd_last_i;
    logic [num_boards_p-1:0]                   brd_ready_o;

    logic                      up_v_o;
    logic [data_width_p-1:0]   up_data_o;
    logic                      up_last_o;
    logic [brd_id_width_p-1:0] up_brd_id_o;
    logic                      up_ready_i;

    logic                      dn_v_i;
    logic [data_width_p-1:0]   dn_data_i;
    logic [brd_id_width_p-1:0] dn_brd_id_i;
    logic                      dn_ready_o;

    logic [num_boards_p-1:0]                   brd_v_o;
    logic [num_boards_p-1:0][data_width_p-1:0] brd_data_o;
    logic [num_boards_p-1:0]                   brd_ready_i;

    logic err_o;

    // Concentrator side.
    modport slave (
        input  brd_v_i, brd_data_i, brd_last_i, up_ready_i,
        input  dn_v_i, dn_data_i, dn_brd_id_i, brd_ready_i,
        output brd_ready_o, up_v_o, up_data_o, up_last_o, up_brd_id_o,
        output dn_ready_o, brd_v_o, brd_data_o, err_o
    );

    // Boards plus core side.
    modport master (
        output brd_v_i, brd_data_i, brd_last_i, up_ready_i,
        output dn_v_i, dn_data_i, dn_brd_id_i, brd_ready_i,
        input  brd_ready_o, up_v_o, up_data_o, up_last_o, up_brd_id_o,
        input  dn_ready_o, brd_v_o, brd_data_o, err_o
    );

endinterface

// File: rtl/qcl_subgroup_board_concentrator_fifo.sv
// Small registered FIFO, one per board channel; no enqueue-to-dequeue bypass.
module qcl_subgroup_board_concentrator_fifo #(
    parameter int unsigned width_p = 33,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_v,
    input  logic [width_p-1:0] enq_data,
    output logic               enq_ready,
    output logic               deq_v,
    output logic [width_p-1:0] deq_data,
    input  logic               deq_yumi
);

    localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wr_q, rd_q;
    logic [cnt_w-1:0]   cnt_q;
    logic               enq, deq;

    // Ready depends only on the registered count, never on a same-cycle dequeue.
    assign enq_ready = ~reset & (cnt_q != cnt_w'(els_p));
    assign deq_v     = (cnt_q != '0);
    assign deq_data  = mem_q[rd_q];
    assign enq       = enq_v & enq_ready;
    assign deq       = deq_yumi & deq_v;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_q] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq) begin
                wr_q <= (wr_q == ptr_w'(els_p - 1)) ? '0 : wr_q + ptr_w'(1);
            end
            if (deq) begin
                rd_q <= (rd_q == ptr_w'(els_p - 1)) ? '0 : rd_q + ptr_w'(1);
            end
            if (enq && !deq) begin
                cnt_q <= cnt_q + cnt_w'(1);
            end else if (deq && !enq) begin
                cnt_q <= cnt_q - cnt_w'(1);
            end
        end
    end

endmodule

// File: rtl/qcl_subgroup_board_concentrator.sv
// Packet-locked round-robin concentration of board links onto one upstream link,
// with a combinational id-steered return path.
module qcl_subgroup_board_concentrator
    import qcl_subgroup_board_concentrator_pkg::*;
#(
    parameter int num_boards_p   = 4,
    parameter int data_width_p   = 32,
    parameter int fifo_els_p     = 4,
    parameter int brd_id_width_p = $clog2(max_proc_nodes_gp)
) (
    input logic clk_i,
    input logic reset_i,
    qcl_subgroup_board_concentrator_if.slave bus
);

    localparam int idx_w  = (num_boards_p > 1) ? $clog2(num_boards_p) : 1;
    localparam int fifo_w = data_width_p + 1;

    logic [num_boards_p-1:0]             fifo_v;
    logic [num_boards_p-1:0]             fifo_yumi;
    logic [num_boards_p-1:0][fifo_w-1:0] fifo_data;

    qcl_conc_state_e state_q, state_d;
    logic [idx_w-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
    logic [idx_w-1:0] scan_idx, cur_gnt;
    logic             scan_hit, cur_req, up_xfer;
    logic             err_q, err_d, dn_in_range;
    int               idx;

    for (genvar i = 0; i < num_boards_p; i++) begin : g_chan
        qcl_subgroup_board_concentrator_fifo #(
            .width_p (fifo_w),
            .els_p   (fifo_els_p)
        ) u_fifo (
            .clk       (clk_i),
            .reset     (reset_i),
            .enq_v     (bus.brd_v_i[i]),
            .enq_data  ({bus.brd_last_i[i], bus.brd_data_i[i]}),
            .enq_ready (bus.brd_ready_o[i]),
            .deq_v     (fifo_v[i]),
            .deq_data  (fifo_data[i]),
            .deq_yumi  (fifo_yumi[i])
        );

        assign fifo_yumi[i] = up_xfer & (cur_gnt == idx_w'(i));
    end

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        idx      = 0;
        for (int k = 0; k < num_boards_p; k++) begin
            idx = (int'(rr_ptr_q) + k) % num_boards_p;
            if (!scan_hit && fifo_v[idx_w'(idx)]) begin
                scan_hit = 1'b1;
                scan_idx = idx_w'(idx);
            end
        end
    end

    // Grant is resolved in the same cycle as IDLE so packets run back to back.
    assign cur_gnt         = (state_q == LOCK) ? gnt_q : scan_idx;
    assign cur_req         = (state_q == LOCK) | scan_hit;
    assign bus.up_v_o      = ~reset_i & cur_req & fifo_v[cur_gnt];
    assign bus.up_data_o   = fifo_data[cur_gnt][data_width_p-1:0];
    assign bus.up_last_o   = fifo_data[cur_gnt][data_width_p];
    assign bus.up_brd_id_o = brd_id_width_p'(cur_gnt);
    assign up_xfer         = bus.up_v_o & bus.up_ready_i;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && scan_hit) begin
            state_d = LOCK;
            gnt_d   = scan_idx;
        end
        if (up_xfer && bus.up_last_o) begin
            state_d  = IDLE;
            rr_ptr_d = (int'(cur_gnt) == num_boards_p - 1) ? '0 : cur_gnt + idx_w'(1);
        end
    end

    assign dn_in_range = int'(bus.dn_brd_id_i) < num_boards_p;

    always_comb begin
        bus.brd_v_o    = '0;
        bus.dn_ready_o = ~dn_in_range;
        for (int i = 0; i < num_boards_p; i++) begin
            bus.brd_data_o[i] = bus.dn_data_i;
            if (int'(bus.dn_brd_id_i) == i) begin
                bus.brd_v_o[i] = bus.dn_v_i;
                bus.dn_ready_o = bus.brd_ready_i[i];
            end
        end
        if (reset_i) begin
            bus.brd_v_o    = '0;
            bus.dn_ready_o = 1'b0;
        end
    end

    assign err_d     = err_q | (~reset_i & bus.dn_v_i & ~dn_in_range);
    assign bus.err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_qcl_subgroup_board_concentrator.sv
// Directed bench for the board concentrator: upstream arbitration, back-pressure,
// return steering, error flag and mid-packet reset.
module tb_qcl_subgroup_board_concentrator;

    logic clk;
    logic reset;
    int   total  = 0;
    int   passes = 0;

    qcl_subgroup_board_concentrator_if #(
        .num_boards_p   (4),
        .data_width_p   (32),
        .brd_id_width_p (3)
    ) bus ();

    qcl_subgroup_board_concentrator #(
        .num_boards_p   (4),
        .data_width_p   (32),
        .fifo_els_p     (4),
        .brd_id_width_p (3)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic up_chk(input string tag, input logic [31:0] d, input logic [2:0] id,
                          input logic last);
        chk({tag, ".v"}, 64'(bus.up_v_o), 64'd1);
        chk({tag, ".data"}, 64'(bus.up_data_o), 64'(d));
        chk({tag, ".id"}, 64'(bus.up_brd_id_o), 64'(id));
        chk({tag, ".last"}, 64'(bus.up_last_o), 64'(last));
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        bus.brd_v_i     = '0;
        bus.brd_data_i  = '0;
        bus.brd_last_i  = '0;
        bus.up_ready_i  = 1'b1;
        bus.dn_v_i      = 1'b1;
        bus.dn_data_i   = 32'h1234;
        bus.dn_brd_id_i = 3'd7;
        bus.brd_ready_i = 4'hF;

        // Reset: outputs held inactive; an out-of-range return beat must not set err.
        cyc();
        settle();
        chk("rst.up_v", 64'(bus.up_v_o), 64'd0);
        chk("rst.brd_ready", 64'(bus.brd_ready_o), 64'h0);
        chk("rst.dn_ready", 64'(bus.dn_ready_o), 64'd0);
        bus.dn_brd_id_i = 3'd1;
        settle();
        chk("rst.brd_v_o", 64'(bus.brd_v_o), 64'h0);
        cyc();
        reset      = 1'b0;
        bus.dn_v_i = 1'b0;
        settle();
        chk("rel.brd_ready", 64'(bus.brd_ready_o), 64'hF);
        chk("rel.err", 64'(bus.err_o), 64'd0);

        // Board 2 sends a 3-beat packet.
        bus.brd_v_i[2]    = 1'b1;
        bus.brd_data_i[2] = 32'hA0;
        settle();
        chk("t1.no_bypass", 64'(bus.up_v_o), 64'd0);
        cyc();
        bus.brd_data_i[2] = 32'hA1;
        settle();
        up_chk("t1.b0", 32'hA0, 3'd2, 1'b0);
        cyc();
        bus.brd_data_i[2] = 32'hA2;
        bus.brd_last_i[2] = 1'b1;
        settle();
        up_chk("t1.b1", 32'hA1, 3'd2, 1'b0);
        cyc();
        bus.brd_v_i = '0;
        bus.brd_last_i = '0;
        settle();
        up_chk("t1.b2", 32'hA2, 3'd2, 1'b1);
        cyc();
        settle();
        chk("t1.idle", 64'(bus.up_v_o), 64'd0);

        // Reset so the round-robin pointer restarts at board 0.
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        // All four boards present 2-beat packets together.
        bus.brd_v_i = 4'hF;
        for (int p = 0; p < 4; p++) bus.brd_data_i[p] = 32'hC0 + 32'(p * 16);
        cyc();
        for (int p = 0; p < 4; p++) bus.brd_data_i[p] = 32'hC1 + 32'(p * 16);
        bus.brd_last_i = 4'hF;
        settle();
        up_chk("t2.p0b0", 32'hC0, 3'd0, 1'b0);
        cyc();
        bus.brd_v_i    = '0;
        bus.brd_last_i = '0;
        for (int s = 1; s < 8; s++) begin
            settle();
            up_chk($sformatf("t2.s%0d", s), 32'hC0 + 32'((s / 2) * 16 + (s % 2)),
                   3'(s / 2), 1'(s % 2));
            cyc();
        end
        settle();
        chk("t2.idle", 64'(bus.up_v_o), 64'd0);

        // Board 1 stalls mid-packet while board 3 waits.
        bus.brd_v_i[1]    = 1'b1;
        bus.brd_data_i[1] = 32'hD0;
        bus.brd_v_i[3]    = 1'b1;
        bus.brd_data_i[3] = 32'hE0;
        bus.brd_last_i[3] = 1'b1;
        cyc();
        bus.brd_v_i    = '0;
        bus.brd_last_i = '0;
        settle();
        up_chk("t3.d0", 32'hD0, 3'd1, 1'b0);
        cyc();
        for (int s = 0; s < 5; s++) begin
            settle();
            chk($sformatf("t3.stall%0d", s), 64'(bus.up_v_o), 64'd0);
            cyc();
        end
        bus.brd_v_i[1]    = 1'b1;
        bus.brd_data_i[1] = 32'hD1;
        bus.brd_last_i[1] = 1'b1;
        cyc();
        bus.brd_v_i    = '0;
        bus.brd_last_i = '0;
        settle();
        up_chk("t3.d1", 32'hD1, 3'd1, 1'b1);
        cyc();
        settle();
        up_chk("t3.e0", 32'hE0, 3'd3, 1'b1);
        cyc();
        settle();
        chk("t3.idle", 64'(bus.up_v_o), 64'd0);

        // Board 0 fills its FIFO while upstream is stalled.
        bus.up_ready_i = 1'b0;
        bus.brd_v_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.brd_data_i[0] = 32'hF0 + 32'(k);
            settle();
            chk($sformatf("t4.ready%0d", k), 64'(bus.brd_ready_o[0]), 64'd1);
            cyc();
        end
        bus.brd_data_i[0] = 32'hF4;
        bus.brd_last_i[0] = 1'b1;
        settle();
        chk("t4.full", 64'(bus.brd_ready_o[0]), 64'd0);
        up_chk("t4.head", 32'hF0, 3'd0, 1'b0);
        cyc();
        settle();
        chk("t4.full_hold", 64'(bus.brd_ready_o[0]), 64'd0);
        bus.up_ready_i = 1'b1;
        settle();
        up_chk("t4.f0", 32'hF0, 3'd0, 1'b0);
        cyc();
        settle();
        chk("t4.space", 64'(bus.brd_ready_o[0]), 64'd1);
        up_chk("t4.f1", 32'hF1, 3'd0, 1'b0);
        cyc();
        bus.brd_v_i    = '0;
        bus.brd_last_i = '0;
        for (int k = 2; k < 5; k++) begin
            settle();
            up_chk($sformatf("t4.f%0d", k), 32'hF0 + 32'(k), 3'd0, 1'(k == 4));
            cyc();
        end
        settle();
        chk("t4.idle", 64'(bus.up_v_o), 64'd0);

        // Return path steering and sticky error.
        bus.dn_v_i      = 1'b1;
        bus.dn_data_i   = 32'h55;
        bus.dn_brd_id_i = 3'd1;
        bus.brd_ready_i = 4'b0111;
        settle();
        chk("t5.id1.v", 64'(bus.brd_v_o), 64'b0010);
        chk("t5.id1.ready", 64'(bus.dn_ready_o), 64'd1);
        chk("t5.data1", 64'(bus.brd_data_o[1]), 64'h55);
        chk("t5.data3", 64'(bus.brd_data_o[3]), 64'h55);
        cyc();
        bus.dn_data_i   = 32'h66;
        bus.dn_brd_id_i = 3'd3;
        settle();
        chk("t5.id3.v", 64'(bus.brd_v_o), 64'b1000);
        chk("t5.id3.ready", 64'(bus.dn_ready_o), 64'd0);
        cyc();
        settle();
        chk("t5.err_clear", 64'(bus.err_o), 64'd0);
        bus.dn_brd_id_i = 3'd7;
        settle();
        chk("t5.id7.ready", 64'(bus.dn_ready_o), 64'd1);
        chk("t5.id7.v", 64'(bus.brd_v_o), 64'h0);
        cyc();
        bus.dn_v_i      = 1'b0;
        bus.brd_ready_i = 4'hF;
        settle();
        chk("t5.err_set", 64'(bus.err_o), 64'd1);
        cyc();
        cyc();
        chk("t5.err_sticky", 64'(bus.err_o), 64'd1);

        // Reset in the middle of a board 0 packet.
        bus.brd_v_i[0]    = 1'b1;
        bus.brd_data_i[0] = 32'h70;
        cyc();
        bus.brd_data_i[0] = 32'h71;
        settle();
        up_chk("t6.g0", 32'h70, 3'd0, 1'b0);
        cyc();
        bus.brd_v_i     = '0;
        reset           = 1'b1;
        bus.dn_v_i      = 1'b1;
        bus.dn_brd_id_i = 3'd1;
        settle();
        chk("t6.rst.up_v", 64'(bus.up_v_o), 64'd0);
        chk("t6.rst.brd_ready", 64'(bus.brd_ready_o), 64'h0);
        chk("t6.rst.dn_ready", 64'(bus.dn_ready_o), 64'd0);
        chk("t6.rst.brd_v", 64'(bus.brd_v_o), 64'h0);
        cyc();
        reset      = 1'b0;
        bus.dn_v_i = 1'b0;
        settle();
        chk("t6.err_cleared", 64'(bus.err_o), 64'd0);
        chk("t6.flushed", 64'(bus.up_v_o), 64'd0);
        bus.brd_v_i[1]    = 1'b1;
        bus.brd_data_i[1] = 32'h80;
        cyc();
        bus.brd_data_i[1] = 32'h81;
        bus.brd_last_i[1] = 1'b1;
        settle();
        up_chk("t6.h0", 32'h80, 3'd1, 1'b0);
        cyc();
        bus.brd_v_i    = '0;
        bus.brd_last_i = '0;
        settle();
        up_chk("t6.h1", 32'h81, 3'd1, 1'b1);
        cyc();
        settle();
        chk("t6.idle0", 64'(bus.up_v_o), 64'd0);
        cyc();
        settle();
        chk("t6.idle1", 64'(bus.up_v_o), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
